// File: rtl/four_bit_alu.sv
// four_bit_alu: 8-operation ALU with registered result, carry, parity and zero flags
module four_bit_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             parity,
  output logic             zero
);
  logic [WIDTH-1:0] r;
  logic             c;
  // next result and carry/borrow/shift-out from the current operands
  always_comb begin
    r = '0;
    c = 1'b0;
    case (s)
      3'd0: {c, r} = {1'b0, a} + {1'b0, b};
      3'd1: begin
        r = a - b;
        c = a < b;
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: {c, r} = {a, 1'b0};
      3'd7: {r, c} = {1'b0, a};
    endcase
  end
  // register result and flags together; reset wins over any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      carryout <= 1'b0;
      parity   <= 1'b0;
      zero     <= 1'b1;
    end else begin
      result   <= r;
      carryout <= c;
      parity   <= ^r;
      zero     <= r == '0;
    end
  end
endmodule

// File: tb/tb_four_bit_alu.sv
// tb_four_bit_alu: scoreboard bench for four_bit_alu
module tb_four_bit_alu;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b;
  logic [2:0] s;
  logic [3:0] result;
  logic       carryout, parity, zero;
  logic [6:0] sb[$];
  logic [6:0] last_e;
  logic       have_last = 1'b0;
  int         n_vec = 0;
  int         n_bad = 0;

  four_bit_alu dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s),
    .result(result), .carryout(carryout), .parity(parity), .zero(zero)
  );

  always #5 clk = ~clk;

  // compare one observed {result,carryout,parity,zero} against its expectation
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got r=%b c=%b p=%b z=%b, want r=%b c=%b p=%b z=%b",
               tag, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // independent reference built from integer arithmetic and bit counting
  function automatic logic [6:0] model(input logic r, input logic [3:0] x, input logic [3:0] y,
                                       input logic [2:0] op);
    int rv, c, p;
    rv = 0;
    c  = 0;
    p  = 0;
    if (r) return 7'b0000_0_0_1;
    case (op)
      3'd0: begin rv = int'(x) + int'(y); c = rv > 15 ? 1 : 0; rv = rv % 16; end
      3'd1: begin rv = (int'(x) - int'(y) + 16) % 16; c = x < y ? 1 : 0; end
      3'd2: rv = int'(x & y);
      3'd3: rv = int'(x | y);
      3'd4: rv = int'(x ^ y);
      3'd5: rv = 15 - int'(x);
      3'd6: begin rv = (int'(x) * 2) % 16; c = int'(x) / 8; end
      3'd7: begin rv = int'(x) / 2; c = int'(x) % 2; end
    endcase
    for (int i = 0; i < 4; i++) p += (rv >> i) & 1;
    return {4'(rv), 1'(c), 1'(p % 2), rv == 0};
  endfunction

  // drive one vector, push its expectation, then compare one edge later
  task automatic run(input string tag, input logic rr, input logic [3:0] aa, input logic [3:0] bb,
                     input logic [2:0] ss, input logic [6:0] e);
    @(negedge clk);
    if (have_last) check({tag, "/hold"}, {result, carryout, parity, zero}, last_e);
    rst = rr;
    a   = aa;
    b   = bb;
    s   = ss;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      last_e = sb.pop_front();
      have_last = 1'b1;
      check(tag, {result, carryout, parity, zero}, last_e);
    end
  endtask

  initial begin
    rst = 1'b1;
    a = 4'hA;
    b = 4'h3;
    s = 3'd2;
    run("rst0", 1, 4'hA, 4'h3, 3'd2, 7'b0000_0_0_1);
    run("rst1", 1, 4'h5, 4'hC, 3'd0, 7'b0000_0_0_1);
    run("rel", 0, 4'd4, 4'd7, 3'd0, 7'b1011_0_1_0);
    run("add", 0, 4'b0100, 4'b0111, 3'd0, 7'b1011_0_1_0);
    run("sub", 0, 4'b0100, 4'b0111, 3'd1, 7'b1101_1_1_0);
    run("and", 0, 4'b0100, 4'b0111, 3'd2, 7'b0100_0_1_0);
    run("or",  0, 4'b0100, 4'b0111, 3'd3, 7'b0111_0_1_0);
    run("xor", 0, 4'b0100, 4'b0111, 3'd4, 7'b0011_0_0_0);
    run("not", 0, 4'b0100, 4'b0111, 3'd5, 7'b1011_0_1_0);
    run("shl", 0, 4'b0100, 4'b0111, 3'd6, 7'b1000_0_1_0);
    run("shr", 0, 4'b0100, 4'b0111, 3'd7, 7'b0010_0_1_0);
    run("addwrap", 0, 4'b1111, 4'b0001, 3'd0, 7'b0000_1_0_1);
    run("subeq", 0, 4'b0101, 4'b0101, 3'd1, 7'b0000_0_0_1);
    run("subbor", 0, 4'b0000, 4'b0001, 3'd1, 7'b1111_1_0_0);
    run("shlout", 0, 4'b1001, 4'b0000, 3'd6, 7'b0010_1_1_0);
    run("shrout", 0, 4'b1001, 4'b0000, 3'd7, 7'b0100_1_1_0);
    run("midrst", 1, 4'b1111, 4'b0001, 3'd0, 7'b0000_0_0_1);
    run("afterrst", 0, 4'b1111, 4'b0001, 3'd0, 7'b0000_1_0_1);
    for (int i = 0; i < 64; i++) begin
      logic       rr;
      logic [3:0] aa, bb;
      logic [2:0] ss;
      rr = ($urandom_range(0, 15) == 0);
      aa = 4'($urandom_range(0, 15));
      bb = 4'($urandom_range(0, 15));
      ss = 3'($urandom_range(0, 7));
      run($sformatf("rnd%0d", i), rr, aa, bb, ss, model(rr, aa, bb, ss));
    end
    @(negedge clk);
    check("final/hold", {result, carryout, parity, zero}, last_e);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/four_bit_alu.md
Name: four_bit_alu

Overview:
- 4-bit, 8-operation ALU with registered outputs: result, carry/borrow, parity and zero flags.
- Operands and opcode are sampled on each rising clock edge; outputs update one cycle later.
- Used as a small datapath arithmetic/logic unit.
- No handshake: a new operation is accepted every cycle.

Parameters:
- WIDTH, 4, operand/result width. Only 4 is required to be supported and verified.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- a  input  4  operand A
- b  input  4  operand B
- s  input  3  operation select
- result  output  4  registered operation result
- carryout  output  1  registered carry/borrow/shift-out flag
- parity  output  1  registered parity flag
- zero  output  1  registered zero flag

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
  - On a rising edge with rst=1: result=0000, carryout=0, parity=0, zero=1.
  - rst has priority over any operation. Asserting rst mid-stream discards the in-flight operation.
  - The first edge after rst deasserts computes from the current a/b/s.
- Latency and throughput:
  - Combinational compute from a, b and s; all four outputs are registered together.
  - Latency is 1 cycle; throughput is 1 operation per cycle.
  - Outputs hold between edges. There are no combinational paths from inputs to outputs.
- Opcodes (s), with all arithmetic modulo 16:
  - 000 ADD: {carryout,result} = a + b (5-bit sum).
  - 001 SUB: result = a − b (two's complement). carryout = 1 iff a < b unsigned (borrow).
  - 010 AND: result = a & b; carryout = 0.
  - 011 OR: result = a | b; carryout = 0.
  - 100 XOR: result = a ^ b; carryout = 0.
  - 101 NOT: result = ~a; b is ignored; carryout = 0.
  - 110 SHL: result = {a[2:0],0}; carryout = a[3].
  - 111 SHR (logical): result = {0,a[3:1]}; carryout = a[0].
- Flags, computed from the new result in the same cycle:
  - parity = XOR of result[3:0], i.e. 1 when the result has an odd number of 1 bits.
  - zero = 1 iff result == 0000.
- Boundary conditions:
  - ADD F+1 wraps to 0000 with carryout=1 and zero=1.
  - SUB with a==b gives 0000, carryout=0, zero=1.
  - SUB 0−1 gives 1111, carryout=1.
  - Shifts discard the outgoing bit into carryout and fill with 0.
- X/undefined s values need not be handled. All 8 encodings are defined, so there is no default/illegal case.

Test Plan:
- Reset: hold rst=1 for 2 edges with arbitrary inputs -> result=0000, carryout=0, parity=0, zero=1. Release rst with a=4, b=7, s=000 -> after 1 edge: result=1011, carryout=0, parity=1, zero=0.
- Opcode sweep, a=0100, b=0111, s=000..111, one per cycle. Required outputs 1 cycle after each (result/carryout/parity/zero):
  - ADD 1011/0/1/0
  - SUB 1101/1/1/0
  - AND 0100/0/1/0
  - OR 0111/0/1/0
  - XOR 0011/0/0/0
  - NOT 1011/0/1/0
  - SHL 1000/0/1/0
  - SHR 0010/0/1/0
- Carry/zero edges:
  - ADD a=1111, b=0001 -> 0000, carryout=1, parity=0, zero=1.
  - SUB a=0101, b=0101 -> 0000, carryout=0, zero=1.
  - SUB a=0000, b=0001 -> 1111, carryout=1, parity=0.
- Shift-out:
  - SHL a=1001 -> 0010, carryout=1.
  - SHR a=1001 -> 0100, carryout=1.
- Reset mid-stream: issue ADD a=1111, b=0001 and assert rst on the same edge -> outputs show reset values, not the ADD result. Next edge with rst=0 shows the ADD result.
- Latency check: change inputs every cycle -> each output set always reflects the inputs sampled at the previous edge. No output change occurs between edges.
